// File: rtl/mac_pkg.sv
// mac_pkg: shared constants for the MAC datapath and its post-accumulation
// stage.
//   IN_W     magnitude width of the sign-magnitude MAC result
//   OUT_W    width of the two's-complement activation
//   NEG_SIGN value of the MAC sign bit that marks a negative result
//   SHAMT_W  width of the programmable right-shift amount
//   SAT_W    width of the saturation event counter
//   ACT_MAX  largest positive activation (saturation value for positives)
//   ACT_MIN  most negative activation (saturation value for negatives)
package mac_pkg;

  localparam int IN_W    = 33;
  localparam int OUT_W   = 16;
  localparam int SHAMT_W = 5;
  localparam int SAT_W   = 16;

  localparam logic NEG_SIGN = 1'b1;

  localparam logic [OUT_W-1:0] ACT_MAX = 16'h7FFF;
  localparam logic [OUT_W-1:0] ACT_MIN = 16'h8000;

endpackage

// File: rtl/mac_act_stage_if.sv
// mac_act_stage_if: input and output handshakes of the activation stage.
//   in_valid/in_ready    MAC result transfer (in_mag, in_sign, relu_en, shamt
//                        travel with it)
//   out_valid/out_ready  activation transfer from the FIFO head (out_data)
// Modports:
//   master  the surrounding logic (MAC side producer, next-layer consumer)
//   slave   the activation stage itself
interface mac_act_stage_if
  import mac_pkg::*;
#(
  parameter int IN_W  = mac_pkg::IN_W,
  parameter int OUT_W = mac_pkg::OUT_W
);

  logic               in_valid;
  logic               in_ready;
  logic [IN_W-1:0]    in_mag;
  logic               in_sign;
  logic               relu_en;
  logic [SHAMT_W-1:0] shamt;

  logic               out_valid;
  logic               out_ready;
  logic [OUT_W-1:0]   out_data;

  modport master (
    output in_valid, in_mag, in_sign, relu_en, shamt, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_mag, in_sign, relu_en, shamt, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/act_fifo.sv
// act_fifo: synchronous circular-buffer FIFO with an occupancy count.
//   clk, rst_n  clock and synchronous active-low reset
//   push, wdata write request and data
//   pop         read request (ignored while empty)
//   rdata       head entry, 0 while empty
//   valid       FIFO holds at least one entry
//   count       number of stored entries, 0..DEPTH
// Pointers are log2(DEPTH) bits and wrap on their own; DEPTH must be a power
// of two. A push and pop in the same cycle is accepted even when full.
module act_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rptr;
  logic [AW-1:0] wptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  // A pop only happens when there is something to read; a push into a full
  // buffer is fine as long as the head leaves in the same cycle.
  always_comb begin
    do_pop  = pop && (cnt != '0);
    do_push = push && ((cnt != FULL_CNT) || do_pop);
  end

  // Storage array is not reset: the count alone decides what is visible.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + 1'b1;
      end
      if (do_pop) begin
        rptr <= rptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Head is masked to zero while empty so stale entries never show.
  always_comb begin
    valid = (cnt != '0);
    rdata = valid ? mem[rptr] : '0;
    count = cnt;
  end

endmodule

// File: rtl/mac_act_stage.sv
// mac_act_stage: post-accumulation stage behind the MAC.
// Takes the sign-magnitude MAC result, applies optional ReLU, a rounding
// (half away from zero) right shift and saturation to a signed OUT_W-bit
// activation, then buffers the result in a DEPTH-entry FIFO.
//   clk, rst_n  clock and synchronous active-low reset
//   bus         mac_act_stage_if.slave: input handshake (in_valid/in_ready
//               with in_mag, in_sign, relu_en, shamt) and output handshake
//               (out_valid/out_ready with out_data)
//   sat_count   number of saturated results written, holds at all-ones
module mac_act_stage
  import mac_pkg::*;
#(
  parameter int   IN_W     = mac_pkg::IN_W,
  parameter int   OUT_W    = mac_pkg::OUT_W,
  parameter int   DEPTH    = 4,
  parameter logic NEG_SIGN = mac_pkg::NEG_SIGN
) (
  input  logic             clk,
  input  logic             rst_n,
  mac_act_stage_if.slave   bus,
  output logic [SAT_W-1:0] sat_count
);

  localparam int CW = $clog2(DEPTH) + 1;

  // Rounded magnitudes above these limits cannot be represented.
  localparam logic [IN_W:0] POS_LIM = (IN_W+1)'((1 << (OUT_W-1)) - 1);
  localparam logic [IN_W:0] NEG_LIM = (IN_W+1)'(1 << (OUT_W-1));
  localparam logic [IN_W:0] ONE     = (IN_W+1)'(1);
  localparam logic [CW:0]   OCC_MAX = (CW+1)'(DEPTH);

  logic               accept;
  logic               s1_valid;
  logic [IN_W-1:0]    s1_mag;
  logic               s1_neg;
  logic               s1_relu;
  logic [SHAMT_W-1:0] s1_shamt;

  logic [IN_W:0]      round_add;
  logic [IN_W:0]      sum;
  logic [IN_W:0]      r;
  logic [OUT_W-1:0]   result;
  logic               sat;

  logic [CW-1:0]      fifo_count;
  logic [CW:0]        occupancy;
  logic               pop;

  // Space check counts the result still sitting in stage 1, so anything
  // accepted here is guaranteed a FIFO slot on the following cycle.
  always_comb begin
    occupancy    = {1'b0, fifo_count} + {{CW{1'b0}}, s1_valid};
    bus.in_ready = rst_n && (occupancy < OCC_MAX);
    accept       = bus.in_valid && bus.in_ready;
    pop          = bus.out_ready && bus.out_valid;
  end

  // Stage 1 captures the operand and its per-transfer controls together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mag   <= '0;
      s1_neg   <= 1'b0;
      s1_relu  <= 1'b0;
      s1_shamt <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_mag   <= bus.in_mag;
        s1_neg   <= (bus.in_sign == NEG_SIGN);
        s1_relu  <= bus.relu_en;
        s1_shamt <= bus.shamt;
      end
    end
  end

  // Round on the magnitude before applying the sign, which gives half away
  // from zero for both signs. The adder is one bit wider than the magnitude
  // so a carry out of the top bit survives the shift.
  always_comb begin
    round_add = '0;
    result    = '0;
    sat       = 1'b0;
    if (s1_shamt != '0) begin
      round_add = ONE << (s1_shamt - 1'b1);
    end
    sum = {1'b0, s1_mag} + round_add;
    r   = sum >> s1_shamt;
    if (s1_neg && s1_relu) begin
      result = '0;
    end else if (!s1_neg) begin
      if (r > POS_LIM) begin
        result = OUT_W'(ACT_MAX);
        sat    = 1'b1;
      end else begin
        result = r[OUT_W-1:0];
      end
    end else begin
      if (r > NEG_LIM) begin
        result = OUT_W'(ACT_MIN);
        sat    = 1'b1;
      end else begin
        result = -r[OUT_W-1:0];
      end
    end
  end

  // Saturation events are counted as they are written into the FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sat_count <= '0;
    end else if (s1_valid && sat && (sat_count != '1)) begin
      sat_count <= sat_count + 1'b1;
    end
  end

  act_fifo #(
    .DEPTH (DEPTH),
    .W     (OUT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (s1_valid),
    .wdata (result),
    .pop   (pop),
    .rdata (bus.out_data),
    .valid (bus.out_valid),
    .count (fifo_count)
  );

endmodule
